// File: rtl/mix_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_mul_seq
// Description : Sequential sign-magnitude multiplier for the MIX execute unit;
//               retires RADIX_BITS multiplier bits per cycle into a 2W product.
// Revision    : 1.0 - initial parametrised release with busy/abort
// ============================================================================
module mix_mul_seq #(
  parameter int BYTE_BITS  = 6,
  parameter int BYTES      = 5,
  parameter int RADIX_BITS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [BYTE_BITS*BYTES:0]       in1,
  input  logic [BYTE_BITS*BYTES:0]       in2,
  output logic [2*BYTE_BITS*BYTES-1:0]   out,
  output logic                           sign,
  output logic                           stop,
  output logic                           busy
);

  localparam int c_w     = BYTE_BITS * BYTES;
  localparam int c_k     = RADIX_BITS;
  localparam int c_iter  = c_w / c_k;
  localparam int c_cnt_w = (c_iter > 1) ? $clog2(c_iter) : 1;

  generate
    if ((c_w % c_k) != 0) begin : g_bad_radix
      $error("mix_mul_seq: word width must be a multiple of RADIX_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_w-1:0]       r_m;
  logic [2*c_w-1:0]     r_p;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*c_w-1:0]     r_out;
  logic                 r_sign;
  logic                 r_stop;
  logic                 r_busy;

  logic [c_k-1:0]       w_d;
  logic [c_w+c_k-1:0]   w_sum;
  logic [2*c_w-1:0]     w_next;

  // Upper partial sum kept W+K wide so the carry survives the right shift.
  assign w_d   = r_p[c_k-1:0];
  assign w_sum = {{c_k{1'b0}}, r_p[2*c_w-1:c_w]}
               + ({{c_k{1'b0}}, r_m} * {{c_w{1'b0}}, w_d});

  generate
    if (c_k == c_w) begin : g_single_step
      assign w_next = w_sum;
    end else begin : g_multi_step
      assign w_next = {w_sum, r_p[c_w-1:c_k]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_sign  <= 1'b0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stop <= 1'b0;
          if (start) begin
            r_m     <= in1[c_w-1:0];
            r_p     <= {{c_w{1'b0}}, in2[c_w-1:0]};
            r_sign  <= in1[c_w] ^ in2[c_w];
            r_cnt   <= c_cnt_w'(c_iter - 1);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_p   <= w_next;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_cnt == '0) begin
              r_out   <= w_next;
              r_stop  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_stop  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign sign = r_sign;
  assign stop = r_stop;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mix_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_mul_seq
// Description : Directed and randomized checks of mix_mul_seq in three builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_mul_seq;

  localparam int W0 = 30;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               start0, abort0, sign0, stop0, busy0;
  logic [W0:0]        a0, b0;
  logic [2*W0-1:0]    out0;
  logic               start1, abort1, sign1, stop1, busy1;
  logic [W0:0]        a1, b1;
  logic [2*W0-1:0]    out1;
  logic               start2, abort2, sign2, stop2, busy2;
  logic [W2:0]        a2, b2;
  logic [2*W2-1:0]    out2;

  mix_mul_seq dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .in1(a0), .in2(b0),
    .out(out0), .sign(sign0), .stop(stop0), .busy(busy0));

  mix_mul_seq #(.RADIX_BITS(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .in1(a1), .in2(b1),
    .out(out1), .sign(sign1), .stop(stop1), .busy(busy1));

  mix_mul_seq #(.BYTE_BITS(8), .BYTES(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .in1(a2), .in2(b2),
    .out(out2), .sign(sign2), .stop(stop2), .busy(busy2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single operation on the default build; returns cycles from start to stop.
  task automatic op0(input logic [W0:0] x, input logic [W0:0] y,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    a0 = x; b0 = y; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; lat = 1; busy_cnt = 0;
    while (!stop0 && lat < 100) begin
      if (busy0) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [W0:0] sm30(input logic neg, input logic [W0-1:0] mag);
    return {neg, mag};
  endfunction

  initial begin
    int lat, bc, nstop, stopat, busy_after;
    logic [63:0] out_at;
    logic [63:0] m0a, m0b, m1a, m1b, m2a, m2b;
    int l0, l1, l2;
    logic [63:0] o0, o1, o2;
    logic s0, s1, s2;

    start0 = 0; abort0 = 0; a0 = '0; b0 = '0;
    start1 = 0; abort1 = 0; a1 = '0; b1 = '0;
    start2 = 0; abort2 = 0; a2 = '0; b2 = '0;
    reset = 1'b0;
    #1;
    check("reset_out",  64'(out0), 64'd0);
    check("reset_sign", 64'(sign0), 64'd0);
    check("reset_stop", 64'(stop0), 64'd0);
    check("reset_busy", 64'(busy0), 64'd0);
    #20 reset = 1'b1;

    // Basic product, latency and busy width
    op0(sm30(1'b0, 30'd3), sm30(1'b0, 30'd5), lat, bc);
    check("t1_latency", 64'(lat), 64'd31);
    check("t1_busy_cycles", 64'(bc), 64'd30);
    check("t1_out", 64'(out0), 64'd15);
    check("t1_sign", 64'(sign0), 64'd0);
    check("t1_busy_at_stop", 64'(busy0), 64'd0);
    @(negedge clk);
    check("t1_stop_pulse", 64'(stop0), 64'd0);
    check("t1_out_hold", 64'(out0), 64'd15);

    // Full-scale magnitudes
    op0(sm30(1'b1, 30'h3FFFFFFF), sm30(1'b0, 30'h3FFFFFFF), lat, bc);
    check("t2_out", 64'(out0), 64'h0FFFFFFF_80000001);
    check("t2_sign", 64'(sign0), 64'd1);

    // Signed zeros
    op0(sm30(1'b1, 30'd0), sm30(1'b0, 30'd7), lat, bc);
    check("t3a_out", 64'(out0), 64'd0);
    check("t3a_sign", 64'(sign0), 64'd1);
    op0(sm30(1'b0, 30'd0), sm30(1'b1, 30'd0), lat, bc);
    check("t3b_out", 64'(out0), 64'd0);
    check("t3b_sign", 64'(sign0), 64'd1);

    // Starts during RUN and DONE must be ignored
    @(negedge clk);
    a0 = sm30(1'b0, 30'd2); b0 = sm30(1'b0, 30'd9); start0 = 1'b1;
    nstop = 0; stopat = 0; busy_after = 0; out_at = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (nstop > 0 && busy0) busy_after++;
      if (stop0) begin nstop++; stopat = i; out_at = 64'(out0); end
      a0 = sm30(1'b0, 30'd100); b0 = sm30(1'b1, 30'd100);
      start0 = (i == 5 || i == 30 || (stop0 && nstop == 1));
    end
    start0 = 1'b0;
    check("t4_stop_count", 64'(nstop), 64'd1);
    check("t4_stop_at", 64'(stopat), 64'd31);
    check("t4_out_at_stop", out_at, 64'd18);
    check("t4_busy_after", 64'(busy_after), 64'd0);
    check("t4_out_hold", 64'(out0), 64'd18);
    check("t4_sign_hold", 64'(sign0), 64'd0);

    // Abort mid-run
    @(negedge clk);
    a0 = sm30(1'b0, 30'd11); b0 = sm30(1'b0, 30'd13); start0 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("t5_abort_busy", 64'(busy0), 64'd0);
    check("t5_abort_out", 64'(out0), 64'd0);
    nstop = 0;
    for (int i = 0; i < 40; i++) begin
      if (stop0) nstop++;
      @(negedge clk);
    end
    check("t5_abort_no_stop", 64'(nstop), 64'd0);

    // Asynchronous reset during a run
    op0(sm30(1'b1, 30'd3), sm30(1'b0, 30'd5), lat, bc);
    check("t5_pre_out", 64'(out0), 64'd15);
    @(negedge clk);
    a0 = sm30(1'b1, 30'd7); b0 = sm30(1'b0, 30'd9); start0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    check("t5_busy_before_rst", 64'(busy0), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_out", 64'(out0), 64'd0);
    check("t5_rst_sign", 64'(sign0), 64'd0);
    check("t5_rst_stop", 64'(stop0), 64'd0);
    check("t5_rst_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    nstop = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stop0) nstop++;
    end
    check("t5_rst_no_stop", 64'(nstop), 64'd0);

    // Randomized operands on all three builds in parallel
    for (int n = 0; n < 300; n++) begin
      m0a = 64'($urandom) & 64'h3FFFFFFF;  m0b = 64'($urandom) & 64'h3FFFFFFF;
      m1a = 64'($urandom) & 64'h3FFFFFFF;  m1b = 64'($urandom) & 64'h3FFFFFFF;
      m2a = 64'($urandom);                 m2b = 64'($urandom);
      if (n % 16 == 0) begin
        m0a = 64'h3FFFFFFF; m1b = 64'h3FFFFFFF; m2a = 64'hFFFFFFFF; m2b = 64'hFFFFFFFF;
      end
      if (n % 16 == 1) begin
        m0b = 64'd0; m1a = 64'd0; m2b = 64'd1;
      end
      @(negedge clk);
      a0 = {1'($urandom), m0a[W0-1:0]}; b0 = {1'($urandom), m0b[W0-1:0]};
      a1 = {1'($urandom), m1a[W0-1:0]}; b1 = {1'($urandom), m1b[W0-1:0]};
      a2 = {1'($urandom), m2a[W2-1:0]}; b2 = {1'($urandom), m2b[W2-1:0]};
      start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
      l0 = 0; l1 = 0; l2 = 0;
      o0 = '0; o1 = '0; o2 = '0; s0 = 0; s1 = 0; s2 = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        if (stop0 && l0 == 0) begin l0 = c; o0 = 64'(out0); s0 = sign0; end
        if (stop1 && l1 == 0) begin l1 = c; o1 = 64'(out1); s1 = sign1; end
        if (stop2 && l2 == 0) begin l2 = c; o2 = 64'(out2); s2 = sign2; end
      end
      check("rnd_k1_lat", 64'(l0), 64'd31);
      check("rnd_k1_out", o0, m0a * m0b);
      check("rnd_k1_sign", 64'(s0), 64'(a0[W0] ^ b0[W0]));
      check("rnd_k3_lat", 64'(l1), 64'd11);
      check("rnd_k3_out", o1, m1a * m1b);
      check("rnd_k3_sign", 64'(s1), 64'(a1[W0] ^ b1[W0]));
      check("rnd_w32_lat", 64'(l2), 64'd33);
      check("rnd_w32_out", o2, m2a * m2b);
      check("rnd_w32_sign", 64'(s2), 64'(a2[W2] ^ b2[W2]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
